alu_share_arbiter: RTL and testbench

//  Shares the single 32-bit ALU between two requesters: A = integer issue, B = address/branch-compare unit.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu.sv | 53 +++++
 rtl/alu_share_arbiter_rr_arb2.sv | 45 ++++
 rtl/alu_share_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, ALU_control codes and the request payload.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned ALU_OP_W   = 7;
    localparam int unsigned ALU_TAG_W  = 4;

    // ALU_control codes
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 7'b0000000;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 7'b0000001;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 7'b0000010;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 7'b0000011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 7'b0000100;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 7'b0000101;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 7'b0000110;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 7'b0000111;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 7'b0001000;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 7'b0001101;
    localparam logic [ALU_OP_W-1:0] ALU_BEQ  = 7'b0010000;
    localparam logic [ALU_OP_W-1:0] ALU_BNE  = 7'b0010001;
    localparam logic [ALU_OP_W-1:0] ALU_BLT  = 7'b0010100;
    localparam logic [ALU_OP_W-1:0] ALU_BGE  = 7'b0010101;
    localparam logic [ALU_OP_W-1:0] ALU_BLTU = 7'b0010110;
    localparam logic [ALU_OP_W-1:0] ALU_BGEU = 7'b0010111;

    // One requester's operation
    typedef struct packed {
        logic [ALU_DATA_W-1:0] opr1;
        logic [ALU_DATA_W-1:0] opr2;
        logic [ALU_OP_W-1:0]   op;
        logic [ALU_TAG_W-1:0]  tag;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: arithmetic/logic/shift results on alu_out,
// branch compares on branch_flag (alu_out = 0 for pure compares).
// Ports: opr1, opr2 operands; alu_control op code; alu_out result; branch_flag compare outcome.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W
) (
    input  logic [DATA_W-1:0]   opr1,
    input  logic [DATA_W-1:0]   opr2,
    input  logic [ALU_OP_W-1:0] alu_control,
    output logic [DATA_W-1:0]   alu_out,
    output logic                branch_flag
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh;
    logic            eq;
    logic            lt_s;
    logic            lt_u;

    assign sh   = opr2[SH_W-1:0];
    assign eq   = (opr1 == opr2);
    assign lt_s = ($signed(opr1) < $signed(opr2));
    assign lt_u = (opr1 < opr2);

    // Operation decode
    always_comb begin
        alu_out     = '0;
        branch_flag = 1'b0;
        case (alu_control)
            ALU_ADD:  alu_out = opr1 + opr2;
            ALU_SUB:  alu_out = opr1 - opr2;
            ALU_AND:  alu_out = opr1 & opr2;
            ALU_OR:   alu_out = opr1 | opr2;
            ALU_XOR:  alu_out = opr1 ^ opr2;
            ALU_SLL:  alu_out = opr1 << sh;
            ALU_SRL:  alu_out = opr1 >> sh;
            ALU_SRA:  alu_out = DATA_W'($signed(opr1) >>> sh);
            ALU_SLT:  alu_out = DATA_W'(lt_s);
            ALU_SLTU: alu_out = DATA_W'(lt_u);
            ALU_BEQ:  branch_flag = eq;
            ALU_BNE:  branch_flag = !eq;
            ALU_BLT:  branch_flag = lt_s;
            ALU_BGE:  branch_flag = !lt_s;
            ALU_BLTU: branch_flag = lt_u;
            ALU_BGEU: branch_flag = !lt_u;
            default:  alu_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way arbiter with round-robin pointer or fixed A-over-B priority.
// Ports: clk, rst; a_valid/b_valid requests; can_acc downstream space;
// a_ready/b_ready handshake (combinational, forced 0 in reset); grant_b selected side; accept handshake fired.
module rr_arb2 #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic b_valid,
    input  logic can_acc,
    output logic a_ready,
    output logic b_ready,
    output logic grant_b,
    output logic accept
);

    localparam logic USE_RR = (PRIO_MODE == 0);

    logic ptr_b;

    // Grant: a lone requester always wins; contention resolved by mode
    always_comb begin
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            grant_b = USE_RR ? ptr_b : 1'b0;
        end else if (b_valid) begin
            grant_b = 1'b1;
        end
    end

    assign a_ready = !rst && can_acc && !grant_b;
    assign b_ready = !rst && can_acc && grant_b;
    assign accept  = (a_valid && a_ready) || (b_valid && b_ready);

    // Pointer favours the side that was not just served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_b <= 1'b0;
        end else if (accept) begin
            ptr_b <= !grant_b;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between requester A (integer issue) and B (address/branch compare).
// The granted request drives the ALU combinationally; the result is captured in a
// one-deep valid/ready register together with its tag and source.
// Ports: clk, rst; a_*/b_* request channels (valid, ready, opr1, opr2, op, tag);
// res_* result channel (valid, ready, data, branch, src, tag); clr_cnt and a_grants/b_grants accept counters.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W    = ALU_DATA_W,
    parameter int unsigned OP_W      = ALU_OP_W,
    parameter int unsigned TAG_W     = ALU_TAG_W,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_opr1,
    input  logic [DATA_W-1:0] a_opr2,
    input  logic [OP_W-1:0]   a_op,
    input  logic [TAG_W-1:0]  a_tag,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_opr1,
    input  logic [DATA_W-1:0] b_opr2,
    input  logic [OP_W-1:0]   b_op,
    input  logic [TAG_W-1:0]  b_tag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_branch,
    output logic              res_src,
    output logic [TAG_W-1:0]  res_tag,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  a_grants,
    output logic [CNT_W-1:0]  b_grants
);

    alu_req_t          a_req;
    alu_req_t          b_req;
    alu_req_t          sel_req;
    logic              can_acc;
    logic              grant_b;
    logic              accept;
    logic [DATA_W-1:0] alu_out;
    logic              branch_flag;
    logic [CNT_W-1:0]  a_grants_nxt;
    logic [CNT_W-1:0]  b_grants_nxt;

    assign a_req = '{opr1: a_opr1, opr2: a_opr2, op: a_op, tag: a_tag};
    assign b_req = '{opr1: b_opr1, opr2: b_opr2, op: b_op, tag: b_tag};

    // Room in the result register now, or it empties on this edge
    assign can_acc = !res_valid || res_ready;

    rr_arb2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .can_acc (can_acc),
        .a_ready (a_ready),
        .b_ready (b_ready),
        .grant_b (grant_b),
        .accept  (accept)
    );

    // Idle cycles leave grant_b at 0, so the ALU sees A's operands
    assign sel_req = grant_b ? b_req : a_req;

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opr1        (sel_req.opr1),
        .opr2        (sel_req.opr2),
        .alu_control (sel_req.op),
        .alu_out     (alu_out),
        .branch_flag (branch_flag)
    );

    // Result register: reload on accept, hold while stalled, empty on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_branch <= 1'b0;
            res_src    <= 1'b0;
            res_tag    <= '0;
        end else begin
            if (accept) begin
                res_valid  <= 1'b1;
                res_data   <= alu_out;
                res_branch <= branch_flag;
                res_src    <= grant_b;
                res_tag    <= sel_req.tag;
            end else if (res_ready) begin
                res_valid  <= 1'b0;
            end
        end
    end

    // Saturating grant counters; clear overrides a same-cycle increment
    always_comb begin
        a_grants_nxt = a_grants;
        b_grants_nxt = b_grants;
        if (clr_cnt) begin
            a_grants_nxt = '0;
            b_grants_nxt = '0;
        end else if (accept) begin
            if (!grant_b && (a_grants != {CNT_W{1'b1}})) begin
                a_grants_nxt = a_grants + CNT_W'(1);
            end
            if (grant_b && (b_grants != {CNT_W{1'b1}})) begin
                b_grants_nxt = b_grants + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_grants <= '0;
            b_grants <= '0;
        end else begin
            a_grants <= a_grants_nxt;
            b_grants <= b_grants_nxt;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a reference model predicts grants,
// readies, counters and results; expected results are queued on accept and
// compared when the result register is drained.
module tb_alu_share_arbiter;

    localparam logic [6:0] OP_ADD = 7'b0000000;
    localparam logic [6:0] OP_SUB = 7'b0001000;
    localparam logic [6:0] OP_BEQ = 7'b0010000;
    localparam logic [6:0] OP_BNE = 7'b0010001;

    typedef struct packed {
        logic [31:0] data;
        logic        br;
        logic        src;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // round-robin instance
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [31:0] a_opr1, a_opr2, b_opr1, b_opr2;
    logic [6:0]  a_op, b_op;
    logic [3:0]  a_tag, b_tag;
    logic        res_valid, res_ready, res_branch, res_src;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic        clr_cnt;
    logic [15:0] a_grants, b_grants;
    // fixed-priority instance with 2-bit counters
    logic        p_a_valid, p_a_ready, p_b_valid, p_b_ready;
    logic        p_res_valid, p_res_ready, p_res_branch, p_res_src;
    logic [31:0] p_res_data;
    logic [3:0]  p_res_tag;
    logic        p_clr_cnt;
    logic [1:0]  p_a_grants, p_b_grants;

    int checks   = 0;
    int failures = 0;

    exp_t        sb[$];
    logic        m_ptr = 1'b0;
    logic        m_rv  = 1'b0;
    logic [15:0] m_ac  = '0;
    logic [15:0] m_bc  = '0;
    logic        m_gb, m_can, m_ar, m_br, m_acc;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_opr1(a_opr1), .a_opr2(a_opr2), .a_op(a_op), .a_tag(a_tag),
        .b_valid(b_valid), .b_ready(b_ready), .b_opr1(b_opr1), .b_opr2(b_opr2), .b_op(b_op), .b_tag(b_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_branch(res_branch),
        .res_src(res_src), .res_tag(res_tag),
        .clr_cnt(clr_cnt), .a_grants(a_grants), .b_grants(b_grants)
    );

    alu_share_arbiter #(.CNT_W(2), .PRIO_MODE(1)) dut_p (
        .clk(clk), .rst(rst),
        .a_valid(p_a_valid), .a_ready(p_a_ready), .a_opr1(a_opr1), .a_opr2(a_opr2), .a_op(a_op), .a_tag(a_tag),
        .b_valid(p_b_valid), .b_ready(p_b_ready), .b_opr1(b_opr1), .b_opr2(b_opr2), .b_op(b_op), .b_tag(b_tag),
        .res_valid(p_res_valid), .res_ready(p_res_ready), .res_data(p_res_data), .res_branch(p_res_branch),
        .res_src(p_res_src), .res_tag(p_res_tag),
        .clr_cnt(p_clr_cnt), .a_grants(p_a_grants), .b_grants(p_b_grants)
    );

    function automatic exp_t ref_res(input logic [6:0] op, input logic [31:0] x, input logic [31:0] y,
                                     input logic src, input logic [3:0] tag);
        exp_t r;
        r.data = '0;
        r.br   = 1'b0;
        r.src  = src;
        r.tag  = tag;
        case (op)
            OP_ADD:  r.data = x + y;
            OP_SUB:  r.data = x - y;
            OP_BEQ:  r.br   = (x == y);
            OP_BNE:  r.br   = (x != y);
            default: r.data = '0;
        endcase
        return r;
    endfunction

    // Reference arbitration for the round-robin instance
    assign m_gb  = (a_valid && b_valid) ? m_ptr : (b_valid && !a_valid);
    assign m_can = !m_rv || res_ready;
    assign m_ar  = !rst && m_can && !m_gb;
    assign m_br  = !rst && m_can && m_gb;
    assign m_acc = (a_valid && m_ar) || (b_valid && m_br);

    // Scoreboard and model state, evaluated mid-cycle on stable inputs
    always @(negedge clk) begin
        logic acc, gb, ar, br;
        exp_t e;
        exp_t got;
        acc = m_acc;
        gb  = m_gb;
        ar  = m_ar;
        br  = m_br;
        if (rst) begin
            m_ptr = 1'b0;
            m_rv  = 1'b0;
            m_ac  = '0;
            m_bc  = '0;
            sb.delete();
        end else begin
            checks++;
            if (res_valid !== m_rv) begin
                failures++;
                $display("FAIL res_valid_track: got %b want %b @%0t", res_valid, m_rv, $time);
            end
            checks++;
            if (a_grants !== m_ac || b_grants !== m_bc) begin
                failures++;
                $display("FAIL grant_counters: got %0d/%0d want %0d/%0d @%0t", a_grants, b_grants, m_ac, m_bc, $time);
            end
            if (res_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow: got result %h with no expected entry @%0t", res_data, $time);
                end else begin
                    e   = sb.pop_front();
                    got = '{data: res_data, br: res_branch, src: res_src, tag: res_tag};
                    if (got !== e) begin
                        failures++;
                        $display("FAIL result: got data=%h br=%b src=%b tag=%h want data=%h br=%b src=%b tag=%h @%0t",
                                 got.data, got.br, got.src, got.tag, e.data, e.br, e.src, e.tag, $time);
                    end
                end
            end
            if (acc) begin
                sb.push_back(gb ? ref_res(b_op, b_opr1, b_opr2, 1'b1, b_tag)
                                : ref_res(a_op, a_opr1, a_opr2, 1'b0, a_tag));
            end
            if (clr_cnt) begin
                m_ac = '0;
                m_bc = '0;
            end else begin
                if (a_valid && ar && m_ac != 16'hffff) m_ac = m_ac + 16'd1;
                if (b_valid && br && m_bc != 16'hffff) m_bc = m_bc + 16'd1;
            end
            m_rv = acc || (m_rv && !res_ready);
            if (acc) m_ptr = !gb;
        end
    end

    task automatic idle_inputs();
        a_valid = 0; a_opr1 = '0; a_opr2 = '0; a_op = OP_ADD; a_tag = '0;
        b_valid = 0; b_opr1 = '0; b_opr2 = '0; b_op = OP_ADD; b_tag = '0;
        res_ready = 1; clr_cnt = 0;
        p_a_valid = 0; p_b_valid = 0; p_res_ready = 1; p_clr_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        a_valid = 1; b_valid = 1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b ar=%b br=%b want 0/0/0", res_valid, a_ready, b_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_grants !== 16'd0 || b_grants !== 16'd0 || res_data !== 32'd0 || res_tag !== 4'd0) begin
            failures++;
            $display("FAIL reset_values: got cnt=%0d/%0d data=%h tag=%h want 0", a_grants, b_grants, res_data, res_tag);
        end
        #1 rst = 0;
        idle_inputs();
    endtask

    task automatic test_a_only();
        do_reset();
        @(posedge clk); #1;
        a_valid = 1; a_opr1 = 32'd5; a_opr2 = 32'd7; a_op = OP_ADD; a_tag = 4'd3;
        #2;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL a_only_ready: got %b/%b want 1/0", a_ready, b_ready);
        end
        @(posedge clk); #1;
        a_valid = 0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd12 || res_src !== 1'b0 || res_tag !== 4'd3 || a_grants !== 16'd1) begin
            failures++;
            $display("FAIL a_only_result: got v=%b data=%0d src=%b tag=%0d cnt=%0d want 1/12/0/3/1",
                     res_valid, res_data, res_src, res_tag, a_grants);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a_valid = 1; a_op = OP_ADD; a_opr1 = 32'(i); a_opr2 = 32'd10; a_tag = 4'(i);
            b_valid = 1; b_op = OP_SUB; b_opr1 = 32'd100; b_opr2 = 32'(i); b_tag = 4'(i + 8);
            #2;
            checks++;
            if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL rr_grant_%0d: got ar=%b br=%b want %b/%b", i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
            end
        end
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        checks++;
        if (a_grants !== 16'd2 || b_grants !== 16'd2) begin
            failures++;
            $display("FAIL rr_counts: got %0d/%0d want 2/2", a_grants, b_grants);
        end
    endtask

    task automatic test_stall();
        do_reset();
        @(posedge clk); #1;
        a_valid = 1; a_op = OP_ADD; a_opr1 = 32'd1; a_opr2 = 32'd2; a_tag = 4'd1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            a_valid = 0;
            b_valid = 1; b_op = OP_SUB; b_opr1 = 32'd9; b_opr2 = 32'd4; b_tag = 4'd5;
            res_ready = (i == 4);
            #2;
            checks++;
            if (b_ready !== (i == 4) || res_valid !== 1'b1 || res_data !== 32'd3 || res_tag !== 4'd1) begin
                failures++;
                $display("FAIL stall_%0d: got br=%b v=%b data=%0d tag=%0d want %b/1/3/1",
                         i, b_ready, res_valid, res_data, res_tag, (i == 4));
            end
        end
        @(posedge clk); #1;
        b_valid = 0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd5 || res_src !== 1'b1 || res_tag !== 4'd5) begin
            failures++;
            $display("FAIL stall_drain: got v=%b data=%0d src=%b tag=%0d want 1/5/1/5", res_valid, res_data, res_src, res_tag);
        end
    endtask

    task automatic test_branch();
        do_reset();
        @(posedge clk); #1;
        b_valid = 1; b_op = OP_BEQ; b_opr1 = 32'h10; b_opr2 = 32'h10; b_tag = 4'd2;
        @(posedge clk); #1;
        b_op = OP_BNE; b_tag = 4'd6;
        checks++;
        if (res_branch !== 1'b1 || res_data !== 32'd0 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL beq_taken: got br=%b data=%h rdy=%b want 1/0/1", res_branch, res_data, b_ready);
        end
        @(posedge clk); #1;
        b_valid = 0;
        checks++;
        if (res_branch !== 1'b0 || res_tag !== 4'd6 || res_src !== 1'b1) begin
            failures++;
            $display("FAIL bne_not_taken: got br=%b tag=%0d src=%b want 0/6/1", res_branch, res_tag, res_src);
        end
    endtask

    task automatic test_clear();
        do_reset();
        @(posedge clk); #1;
        a_valid = 1; a_op = OP_ADD; a_opr1 = 32'd3; a_opr2 = 32'd3; a_tag = 4'd7;
        @(posedge clk); #1;
        clr_cnt = 1;
        #2;
        checks++;
        if (a_grants !== 16'd1 || a_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_pre: got cnt=%0d rdy=%b want 1/1", a_grants, a_ready);
        end
        @(posedge clk); #1;
        a_valid = 0; clr_cnt = 0;
        checks++;
        if (a_grants !== 16'd0) begin
            failures++;
            $display("FAIL clr_wins: got %0d want 0", a_grants);
        end
    endtask

    task automatic test_prio_saturate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            p_a_valid = 1; p_b_valid = 1;
            #2;
            checks++;
            if (p_a_ready !== 1'b1 || p_b_ready !== 1'b0) begin
                failures++;
                $display("FAIL prio_grant_%0d: got ar=%b br=%b want 1/0", i, p_a_ready, p_b_ready);
            end
            if (i == 3) begin
                checks++;
                if (p_a_grants !== 2'd3 || p_b_grants !== 2'd0) begin
                    failures++;
                    $display("FAIL prio_counts: got %0d/%0d want 3/0", p_a_grants, p_b_grants);
                end
            end
        end
        @(posedge clk); #1;
        p_a_valid = 0; p_b_valid = 0; p_clr_cnt = 1;
        checks++;
        if (p_a_grants !== 2'd3 || p_res_src !== 1'b0) begin
            failures++;
            $display("FAIL saturate: got cnt=%0d src=%b want 3/0", p_a_grants, p_res_src);
        end
        @(posedge clk); #1;
        p_clr_cnt = 0;
        checks++;
        if (p_a_grants !== 2'd0) begin
            failures++;
            $display("FAIL prio_clear: got %0d want 0", p_a_grants);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(posedge clk); #1;
        a_valid = 1; a_op = OP_ADD; a_opr1 = 32'd2; a_opr2 = 32'd2; a_tag = 4'd9;
        @(posedge clk); #1;
        res_ready = 0;
        b_valid = 1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd4) begin
            failures++;
            $display("FAIL arst_pre: got v=%b data=%0d want 1/4", res_valid, res_data);
        end
        #1 rst = 1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_data !== 32'd0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL arst_async: got v=%b data=%0d ar=%b br=%b want 0/0/0/0", res_valid, res_data, a_ready, b_ready);
        end
        @(posedge clk); #1;
        rst = 0; res_ready = 1;
        #2;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL arst_ptr: got ar=%b br=%b want 1/0", a_ready, b_ready);
        end
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_round_robin();
        test_stall();
        test_branch();
        test_clear();
        test_prio_saturate();
        test_async_reset();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
